// File: rtl/cpu_pkg.sv
// Shared core types: tag type, the "no producer" tag and the CDB broadcast record.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The reservation-station broadcast logic reuses cdb_t.
package cpu_pkg;

  localparam int DEF_NUM_UNITS = 8;
  localparam int DEF_TAG_W     = $clog2(DEF_NUM_UNITS);
  localparam int DEF_DATA_W    = 32;

  typedef logic [DEF_TAG_W-1:0] tag_t;

  // Tag 0 means "value ready, no producer"; it never wins arbitration.
  localparam tag_t TAG_NONE = '0;

  typedef struct packed {
    logic                  valid;
    tag_t                  tag;
    logic [DEF_DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker over slots 1..NUM_UNITS-1 (slot 0 skipped).
// Latency: purely combinational, no state.
// Backpressure: none; produces at most one grant. Ports: req, last -> grant (one-hot), winner, found.
module rr_pick #(
  parameter int NUM_UNITS = 8,
  parameter int TAG_W     = 3
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [TAG_W-1:0]     last,
  output logic [NUM_UNITS-1:0] grant,
  output logic [TAG_W-1:0]     winner,
  output logic                 found
);

  int               cand;
  logic [TAG_W-1:0] idx;

  // Walk last+1, last+2, ... ; anything past NUM_UNITS-1 folds back to 1,
  // so slot 0 is never visited.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    idx    = '0;
    for (int k = 1; k < NUM_UNITS; k++) begin
      cand = int'(last) + k;
      if (cand >= NUM_UNITS) begin
        cand = cand - (NUM_UNITS - 1);
      end
      idx = cand[TAG_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter driving the registered common data bus broadcast.
// Latency: grant is combinational at edge k; broadcast visible from k+1 to k+2.
// Backpressure: none downstream; upstream valid/ready with req_ready as one-hot grant.
// Ports: CLOCK_50, RSTN_N (async active-low), flush, req_valid/req_data in,
//        req_ready out, cdb_valid/cdb_tag/cdb_data out (registered).
// Optional macro CDB_PERF_EN adds saturating perf_grants / perf_conflicts counters.
module cdb_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int TAG_W     = $clog2(NUM_UNITS),
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                             CLOCK_50,
  input  logic                             RSTN_N,
  input  logic                             flush,
  input  logic [NUM_UNITS-1:0]             req_valid,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0] req_data,
  output logic [NUM_UNITS-1:0]             req_ready,
  output logic                             cdb_valid,
  output logic [TAG_W-1:0]                 cdb_tag,
  output logic [DATA_W-1:0]                cdb_data
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]                      perf_grants,
  output logic [31:0]                      perf_conflicts
`endif
);

  // Pointer parks on the top slot so slot 1 has first priority.
  localparam logic [TAG_W-1:0] LAST_RST = TAG_W'(NUM_UNITS - 1);

  logic [NUM_UNITS-1:0] pick_req;
  logic [NUM_UNITS-1:0] pick_grant;
  logic [TAG_W-1:0]     pick_winner;
  logic                 pick_found;
  logic                 grant_en;
  logic                 granted;

  logic [TAG_W-1:0]  last_q, last_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

  rr_pick #(
    .NUM_UNITS(NUM_UNITS),
    .TAG_W    (TAG_W)
  ) u_rr_pick (
    .req   (pick_req),
    .last  (last_q),
    .grant (pick_grant),
    .winner(pick_winner),
    .found (pick_found)
  );

  always_comb begin
    pick_req    = req_valid;
    pick_req[0] = 1'b0;
    // RSTN_N gates ready so nothing looks granted while the flops are held.
    grant_en    = RSTN_N && !flush;
    granted     = grant_en && pick_found;
    req_ready   = grant_en ? pick_grant : '0;

    last_d      = last_q;
    cdb_valid_d = granted;
    cdb_tag_d   = TAG_W'(TAG_NONE);
    cdb_data_d  = '0;
    if (flush) begin
      last_d = LAST_RST;
    end else if (granted) begin
      last_d     = pick_winner;
      cdb_tag_d  = pick_winner;
      cdb_data_d = req_data[pick_winner];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      last_q      <= LAST_RST;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      last_q      <= last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

`ifdef CDB_PERF_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [31:0] perf_conflicts_q, perf_conflicts_d;
  logic        conflict;

  // Counters are statistics only: flush leaves them alone, they stick at all-ones.
  always_comb begin
    conflict         = $countones(req_valid[NUM_UNITS-1:1]) >= 2;
    perf_grants_d    = perf_grants_q;
    perf_conflicts_d = perf_conflicts_q;
    if (granted && (perf_grants_q != 32'hFFFF_FFFF)) begin
      perf_grants_d = perf_grants_q + 32'd1;
    end
    if (conflict && (perf_conflicts_q != 32'hFFFF_FFFF)) begin
      perf_conflicts_d = perf_conflicts_q + 32'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      perf_grants_q    <= '0;
      perf_conflicts_q <= '0;
    end else begin
      perf_grants_q    <= perf_grants_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_grants    = perf_grants_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: vector table, hand-written corner sequences, random traffic
// checked against a queue-free round-robin model (pointer + scan).
// Clock 100 MHz-ish; inputs driven at negedge, outputs sampled #1 after edges.
module tb_cdb_arbiter;

  localparam int N = 8;

  logic               CLOCK_50 = 1'b0;
  logic               RSTN_N;
  logic               flush;
  logic [N-1:0]       req_valid;
  logic [N-1:0][31:0] req_data;
  logic [N-1:0]       req_ready;
  logic               cdb_valid;
  logic [2:0]         cdb_tag;
  logic [31:0]        cdb_data;
`ifdef CDB_PERF_EN
  logic [31:0]        perf_grants;
  logic [31:0]        perf_conflicts;
`endif

  always #5 CLOCK_50 = ~CLOCK_50;

  cdb_arbiter dut (
    .CLOCK_50 (CLOCK_50),
    .RSTN_N   (RSTN_N),
    .flush    (flush),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data)
`ifdef CDB_PERF_EN
    ,
    .perf_grants   (perf_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int t);
    return 32'hA5A0_0000 | 32'(t);
  endfunction

  // Reference rule: candidates last+1 .. in the cyclic order 1..N-1.
  function automatic int model_pick(input logic [N-1:0] rv, input int last);
    logic [N-1:0] r;
    int           t;
    r = rv;
    for (int d = 1; d < N; d++) begin
      t = ((last - 1 + d) % (N - 1)) + 1;
      if (r[t[2:0]]) return t;
    end
    return 0;
  endfunction

  task automatic cycle(input logic [N-1:0] rv, input logic fl, output logic [N-1:0] rdy,
                       output logic v, output logic [2:0] t, output logic [31:0] d);
    @(negedge CLOCK_50);
    req_valid = rv;
    flush     = fl;
    #1;
    rdy = req_ready;
    @(posedge CLOCK_50);
    #1;
    v = cdb_valid;
    t = cdb_tag;
    d = cdb_data;
  endtask

  task automatic do_reset();
    RSTN_N    = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RSTN_N = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic         fl;
    logic [N-1:0] rdy;
    logic         v;
    logic [2:0]   tag;
  } vec_t;

  vec_t         tbl[19];
  logic [N-1:0] rdy, rvx, pend, exp_rdy;
  logic         v, fl;
  logic [2:0]   t;
  logic [31:0]  d;
  logic [31:0]  dat[N];
  int           waitc[N];
  int           m_last, w;

  initial begin
    // Sequence from reset (pointer at 7).
    tbl[0]  = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1]  = '{8'h08, 1'b0, 8'h08, 1'b1, 3'd3};
    tbl[2]  = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[3]  = '{8'hFE, 1'b0, 8'h10, 1'b1, 3'd4};
    tbl[4]  = '{8'hEE, 1'b0, 8'h20, 1'b1, 3'd5};
    tbl[5]  = '{8'hCE, 1'b0, 8'h40, 1'b1, 3'd6};
    tbl[6]  = '{8'h8E, 1'b0, 8'h80, 1'b1, 3'd7};
    tbl[7]  = '{8'h0E, 1'b0, 8'h02, 1'b1, 3'd1};
    tbl[8]  = '{8'h0C, 1'b0, 8'h04, 1'b1, 3'd2};
    tbl[9]  = '{8'h08, 1'b0, 8'h08, 1'b1, 3'd3};
    tbl[10] = '{8'h01, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[11] = '{8'h44, 1'b0, 8'h40, 1'b1, 3'd6};
    tbl[12] = '{8'h44, 1'b0, 8'h04, 1'b1, 3'd2};
    tbl[13] = '{8'h44, 1'b1, 8'h00, 1'b0, 3'd0};
    tbl[14] = '{8'h44, 1'b0, 8'h04, 1'b1, 3'd2};
    tbl[15] = '{8'h22, 1'b0, 8'h20, 1'b1, 3'd5};
    tbl[16] = '{8'h22, 1'b1, 8'h00, 1'b0, 3'd0};
    tbl[17] = '{8'h22, 1'b0, 8'h02, 1'b1, 3'd1};
    tbl[18] = '{8'hFF, 1'b0, 8'h04, 1'b1, 3'd2};

    for (int i = 0; i < N; i++) req_data[i[2:0]] = pat(i);
    RSTN_N    = 1'b0;
    flush     = 1'b0;
    req_valid = 8'hFE;
    #12;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_valid", 32'(cdb_valid), 32'h0);
    chk("reset_tag", 32'(cdb_tag), 32'h0);
    chk("reset_data", cdb_data, 32'h0);

`ifdef CDB_PERF_EN
    do_reset();
    cycle(8'h12, 1'b0, rdy, v, t, d);
    chk("perf_first", 32'(t), 32'd1);
    cycle(8'h12, 1'b0, rdy, v, t, d);
    chk("perf_second", 32'(t), 32'd4);
    cycle(8'h00, 1'b0, rdy, v, t, d);
    chk("perf_grants", perf_grants, 32'd2);
    chk("perf_conflicts", perf_conflicts, 32'd2);
    cycle(8'h12, 1'b0, rdy, v, t, d);
    RSTN_N = 1'b0;
    #1;
    chk("perf_grants_rst", perf_grants, 32'd0);
    chk("perf_conflicts_rst", perf_conflicts, 32'd0);
    chk("perf_valid_rst", 32'(cdb_valid), 32'd0);
`endif

    // Idle after reset.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(8'h00, 1'b0, rdy, v, t, d);
      chk("idle_ready", 32'(rdy), 32'h0);
      chk("idle_valid", 32'(v), 32'h0);
      chk("idle_tag", 32'(t), 32'h0);
    end

    // Table of vectors.
    for (int k = 0; k < 19; k++) begin
      cycle(tbl[k].rv, tbl[k].fl, rdy, v, t, d);
      chk($sformatf("tbl%0d_ready", k), 32'(rdy), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d_valid", k), 32'(v), 32'(tbl[k].v));
      chk($sformatf("tbl%0d_tag", k), 32'(t), 32'(tbl[k].tag));
      chk($sformatf("tbl%0d_data", k), d, tbl[k].v ? pat(int'(tbl[k].tag)) : 32'h0);
    end

    // Full sweep: each unit drops after its grant -> 1..7 back to back.
    do_reset();
    rvx = 8'hFE;
    for (int k = 1; k < N; k++) begin
      cycle(rvx, 1'b0, rdy, v, t, d);
      chk("sweep_valid", 32'(v), 32'h1);
      chk("sweep_tag", 32'(t), 32'(k));
      rvx[k[2:0]] = 1'b0;
    end
    cycle(rvx, 1'b0, rdy, v, t, d);
    chk("sweep_end_valid", 32'(v), 32'h0);

    // Two continuous requesters alternate.
    for (int k = 0; k < 6; k++) begin
      cycle(8'h44, 1'b0, rdy, v, t, d);
      chk("alt_tag", 32'(t), (k % 2 == 0) ? 32'd2 : 32'd6);
    end

    // Flush beats a request; unit is granted right after.
    cycle(8'h20, 1'b1, rdy, v, t, d);
    chk("flush_ready", 32'(rdy), 32'h0);
    chk("flush_valid", 32'(v), 32'h0);
    cycle(8'h20, 1'b0, rdy, v, t, d);
    chk("post_flush_tag", 32'(t), 32'd5);
    // Pointer now 5: without the flush reset unit 6 would win over unit 1.
    cycle(8'h42, 1'b1, rdy, v, t, d);
    chk("flush2_valid", 32'(v), 32'h0);
    cycle(8'h42, 1'b0, rdy, v, t, d);
    chk("flush_ptr_reset", 32'(t), 32'd1);

    // Reset mid-broadcast: output clears at once, arbitration restarts at 1.
    cycle(8'h08, 1'b0, rdy, v, t, d);
    chk("pre_rst_tag", 32'(t), 32'd3);
    RSTN_N    = 1'b0;
    req_valid = '0;
    #1;
    chk("mid_rst_valid", 32'(cdb_valid), 32'h0);
    chk("mid_rst_tag", 32'(cdb_tag), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    @(negedge CLOCK_50);
    RSTN_N = 1'b1;
    cycle(8'h42, 1'b0, rdy, v, t, d);
    chk("post_rst_tag", 32'(t), 32'd1);

    // Random traffic against the model.
    do_reset();
    pend   = '0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 1; i < N; i++) begin
        if (!pend[i[2:0]] && $urandom_range(2) == 0) begin
          pend[i[2:0]]     = 1'b1;
          dat[i[2:0]]      = $urandom;
          req_data[i[2:0]] = dat[i[2:0]];
        end
      end
      fl      = ($urandom_range(15) == 0);
      rvx     = pend;
      rvx[0]  = 1'($urandom_range(1));
      w       = fl ? 0 : model_pick(pend, m_last);
      exp_rdy = '0;
      if (w != 0) exp_rdy[w[2:0]] = 1'b1;
      cycle(rvx, fl, rdy, v, t, d);
      chk("rnd_ready", 32'(rdy), 32'(exp_rdy));
      chk("rnd_valid", 32'(v), (w != 0) ? 32'h1 : 32'h0);
      chk("rnd_tag", 32'(t), 32'(w));
      chk("rnd_data", d, (w != 0) ? dat[w[2:0]] : 32'h0);
      for (int i = 1; i < N; i++) if (pend[i[2:0]]) waitc[i[2:0]]++;
      if (fl) begin
        m_last = N - 1;
        for (int i = 0; i < N; i++) waitc[i[2:0]] = 0;
      end else if (w != 0) begin
        chk("rnd_fair", (waitc[w[2:0]] <= N - 1) ? 32'h1 : 32'h0, 32'h1);
        pend[w[2:0]]  = 1'b0;
        waitc[w[2:0]] = 0;
        m_last        = w;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
